// File: rtl/nexys_starship_spawner.sv
// Monster spawn generator feeding the four lane state machines' *_random inputs.
// A free-running Galois LFSR picks the first lane to try; a tick countdown with a ramp paces spawns.
module nexys_starship_spawner #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          BASE_INTERVAL = 8,
    parameter int          MIN_INTERVAL  = 2,
    parameter int          RAMP_TICKS    = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_tick,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] lane_empty,
    output logic [3:0] spawn,
    output logic [3:0] cur_interval,
    output logic [7:0] spawn_count,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Spawn,
    output logic       q_Halt
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_SPAWN  = 2'd2;
    localparam logic [1:0]  ST_HALT   = 2'd3;
    localparam logic [3:0]  BASE_I    = 4'(BASE_INTERVAL);
    localparam logic [3:0]  MIN_I     = 4'(MIN_INTERVAL);
    localparam logic [7:0]  RAMP_T    = 8'(RAMP_TICKS);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [1:0]  r_state;
    logic [15:0] r_lfsr;
    logic [3:0]  r_interval;
    logic [3:0]  r_countdown;
    logic [7:0]  r_ramp;
    logic [7:0]  r_count;
    logic        r_pending;
    logic [1:0]  r_cand;
    logic [1:0]  r_tries;
    logic [3:0]  r_spawn;

    logic [1:0]  w_state_next;
    logic [3:0]  w_interval_next;
    logic [3:0]  w_countdown_next;
    logic [7:0]  w_ramp_next;
    logic [7:0]  w_count_next;
    logic        w_pending_next;
    logic [1:0]  w_cand_next;
    logic [1:0]  w_tries_next;
    logic [3:0]  w_spawn_next;
    logic        w_reload;

    logic [15:0] w_lfsr_next;
    logic [7:0]  w_ramp_inc;
    logic        w_ramp_wrap;
    logic [3:0]  w_interval_ramped;
    logic        w_expire;
    logic [3:0]  w_cand_onehot;
    logic        w_cand_empty;

    assign w_lfsr_next       = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
    assign w_ramp_inc        = r_ramp + 8'd1;
    assign w_ramp_wrap       = (w_ramp_inc == RAMP_T);
    // The countdown reload uses the interval after this tick's ramp step.
    assign w_interval_ramped = (w_ramp_wrap && (r_interval > MIN_I)) ? r_interval - 4'd1 : r_interval;
    assign w_expire          = timer_tick && (r_countdown == 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign w_cand_onehot[gi] = (r_cand == 2'(gi));
        end
    endgenerate

    assign w_cand_empty = |(w_cand_onehot & lane_empty);

    always_comb begin
        w_state_next     = r_state;
        w_interval_next  = r_interval;
        w_countdown_next = r_countdown;
        w_ramp_next      = r_ramp;
        w_count_next     = r_count;
        w_pending_next   = r_pending;
        w_cand_next      = r_cand;
        w_tries_next     = r_tries;
        w_spawn_next     = 4'b0000;
        w_reload         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_reload = 1'b1;
                if (play_flag) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN, ST_SPAWN: begin
                if (gameover_ctrl) begin
                    w_state_next = ST_HALT;
                end else begin
                    if (timer_tick) begin
                        w_ramp_next      = w_ramp_wrap ? 8'd0 : w_ramp_inc;
                        w_interval_next  = w_interval_ramped;
                        w_countdown_next = w_expire ? w_interval_ramped : r_countdown - 4'd1;
                        if (w_expire) begin
                            w_pending_next = 1'b1;
                        end
                    end
                    if (r_state == ST_RUN) begin
                        if (r_pending) begin
                            w_state_next = ST_SPAWN;
                            w_cand_next  = r_lfsr[1:0];
                            w_tries_next = 2'd0;
                        end
                    end else if (w_cand_empty) begin
                        // A fresh expiry in the same cycle stays queued for the next RUN.
                        w_spawn_next   = w_cand_onehot;
                        w_count_next   = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                        w_pending_next = w_expire;
                        w_state_next   = ST_RUN;
                    end else if (r_tries == 2'd3) begin
                        w_pending_next = w_expire;
                        w_state_next   = ST_RUN;
                    end else begin
                        w_cand_next  = r_cand + 2'd1;
                        w_tries_next = r_tries + 2'd1;
                    end
                end
            end
            default: begin
                if (!gameover_ctrl) begin
                    w_state_next = ST_IDLE;
                    w_reload     = 1'b1;
                end
            end
        endcase

        if (w_reload) begin
            w_interval_next  = BASE_I;
            w_countdown_next = BASE_I;
            w_ramp_next      = 8'd0;
            w_pending_next   = 1'b0;
            w_count_next     = 8'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_interval  <= BASE_I;
            r_countdown <= BASE_I;
            r_ramp      <= 8'd0;
            r_count     <= 8'd0;
            r_pending   <= 1'b0;
            r_cand      <= 2'd0;
            r_tries     <= 2'd0;
            r_spawn     <= 4'b0000;
        end else begin
            r_state     <= w_state_next;
            r_lfsr      <= w_lfsr_next;
            r_interval  <= w_interval_next;
            r_countdown <= w_countdown_next;
            r_ramp      <= w_ramp_next;
            r_count     <= w_count_next;
            r_pending   <= w_pending_next;
            r_cand      <= w_cand_next;
            r_tries     <= w_tries_next;
            r_spawn     <= w_spawn_next;
        end
    end

    assign spawn        = r_spawn;
    assign cur_interval = r_interval;
    assign spawn_count  = r_count;
    assign q_Idle       = (r_state == ST_IDLE);
    assign q_Run        = (r_state == ST_RUN);
    assign q_Spawn      = (r_state == ST_SPAWN);
    assign q_Halt       = (r_state == ST_HALT);

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Randomized bench for nexys_starship_spawner: a tick-level game model predicts spawn pulses
// and state/counter values per cycle into queues that a negedge monitor drains and compares.
module tb_nexys_starship_spawner;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int BASE = 8;
    localparam int MINI = 2;
    localparam int RAMP = 16;

    localparam int K_STATE    = 0;
    localparam int K_COUNT    = 1;
    localparam int K_INTERVAL = 2;
    localparam int K_SPAWN    = 3;

    localparam int ST_IDLE  = 8;
    localparam int ST_RUN   = 4;
    localparam int ST_SPAWN = 2;
    localparam int ST_HALT  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       timer_tick;
    logic       play_flag;
    logic       gameover_ctrl;
    logic [3:0] lane_empty;
    logic [3:0] spawn;
    logic [3:0] cur_interval;
    logic [7:0] spawn_count;
    logic       q_Idle, q_Run, q_Spawn, q_Halt;

    nexys_starship_spawner #(
        .LFSR_SEED(SEED), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MINI), .RAMP_TICKS(RAMP)
    ) dut (
        .Clk(clk), .Reset(rst_n), .timer_tick(timer_tick), .play_flag(play_flag),
        .gameover_ctrl(gameover_ctrl), .lane_empty(lane_empty), .spawn(spawn),
        .cur_interval(cur_interval), .spawn_count(spawn_count),
        .q_Idle(q_Idle), .q_Run(q_Run), .q_Spawn(q_Spawn), .q_Halt(q_Halt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int lane;
        int count;
        int count_before;
        int interval;
    } spawn_t;

    typedef struct {
        int cyc;
        int kind;
        int value;
    } chk_t;

    spawn_t spawn_q[$];
    chk_t   chk_q[$];
    int checks = 0;
    int errors = 0;

    // Game model: 0 idle, 1 running (RUN or SPAWN), 2 halted
    int          m_st = 0;
    logic [15:0] m_lfsr;
    int          m_ticks = 0;
    int          m_next_exp = BASE;
    int          m_count = 0;
    int          m_spawns = 0;
    bit          m_exp = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int interval_after(input int n);
        int v;
        v = BASE - n / RAMP;
        return (v < MINI) ? MINI : v;
    endfunction

    function automatic string kind_name(input int k);
        case (k)
            K_STATE:    return "state";
            K_COUNT:    return "spawn_count";
            K_INTERVAL: return "cur_interval";
            default:    return "spawn";
        endcase
    endfunction

    task automatic expect_at(input int c, input int kind, input int value);
        chk_t e;
        e.cyc = c; e.kind = kind; e.value = value;
        chk_q.push_back(e);
    endtask

    task automatic purge_from(input int c);
        for (int i = spawn_q.size() - 1; i >= 0; i--) begin
            if (spawn_q[i].cyc >= c) begin
                m_count = spawn_q[i].count_before;
                m_spawns--;
                spawn_q.delete(i);
            end
        end
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc >= c) chk_q.delete(i);
        end
    endtask

    task automatic schedule_spawn(input int c);
        logic [15:0] lf;
        logic [1:0]  idx;
        bit          found;
        int          k;
        int          nc;
        spawn_t      e;
        lf = lfsr_step(m_lfsr);
        found = 0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            idx = lf[1:0] + 2'(i);
            if (!found && lane_empty[idx]) begin
                found = 1;
                k = i;
            end
        end
        if (found) begin
            for (int j = 0; j <= k; j++) expect_at(c + 2 + j, K_STATE, ST_SPAWN);
            nc = (m_count < 255) ? m_count + 1 : 255;
            idx = lf[1:0] + 2'(k);
            e.cyc = c + 3 + k; e.lane = int'(idx); e.count = nc;
            e.count_before = m_count; e.interval = interval_after(m_ticks);
            spawn_q.push_back(e);
            m_count = nc;
            m_spawns++;
            expect_at(c + 3 + k, K_STATE, ST_RUN);
        end else begin
            for (int j = 0; j < 4; j++) expect_at(c + 2 + j, K_STATE, ST_SPAWN);
            expect_at(c + 6, K_STATE, ST_RUN);
            expect_at(c + 6, K_COUNT, m_count);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic cycle(input bit tick, input bit play, input bit go);
        int c;
        c = cyc;
        timer_tick = tick;
        play_flag = play;
        gameover_ctrl = go;
        if (rst_n) begin
            case (m_st)
                0: begin
                    if (play) begin
                        m_st = 1; m_ticks = 0; m_next_exp = BASE; m_count = 0;
                        expect_at(c + 1, K_STATE, ST_RUN);
                    end else begin
                        expect_at(c + 1, K_STATE, ST_IDLE);
                    end
                end
                1: begin
                    if (go) begin
                        purge_from(c + 1);
                        m_st = 2;
                        expect_at(c + 1, K_STATE, ST_HALT);
                        expect_at(c + 1, K_COUNT, m_count);
                        expect_at(c + 1, K_INTERVAL, interval_after(m_ticks));
                    end else if (tick) begin
                        m_ticks++;
                        expect_at(c + 1, K_INTERVAL, interval_after(m_ticks));
                        if (m_ticks == m_next_exp) begin
                            m_next_exp = m_ticks + interval_after(m_ticks);
                            m_exp = 1;
                            schedule_spawn(c);
                        end
                    end
                end
                default: begin
                    if (!go) begin
                        m_st = 0; m_count = 0; m_ticks = 0;
                        expect_at(c + 1, K_STATE, ST_IDLE);
                        expect_at(c + 1, K_INTERVAL, BASE);
                        expect_at(c + 1, K_COUNT, 0);
                    end else begin
                        expect_at(c + 1, K_STATE, ST_HALT);
                        expect_at(c + 1, K_COUNT, m_count);
                        expect_at(c + 1, K_INTERVAL, interval_after(m_ticks));
                    end
                end
            endcase
        end
        step();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        purge_from(cyc);
        m_lfsr = SEED; m_st = 0; m_count = 0; m_ticks = 0;
        expect_at(cyc, K_STATE, ST_IDLE);
        expect_at(cyc, K_SPAWN, 0);
        expect_at(cyc, K_COUNT, 0);
        expect_at(cyc, K_INTERVAL, BASE);
    endtask

    task automatic tick_once(input logic [3:0] le, input bit play);
        int gap;
        gap = int'($urandom_range(5, 11));
        repeat (gap) cycle(1'b0, play, 1'b0);
        lane_empty = le;
        cycle(1'b1, play, 1'b0);
    endtask

    task automatic run_to_expiry(input logic [3:0] le);
        m_exp = 0;
        for (int i = 0; i < 64 && !m_exp; i++) tick_once(le, 1'b1);
    endtask

    // Monitor: drains the spawn scoreboard on every pulse and the per-cycle expectations.
    initial begin
        logic [3:0] prev_spawn;
        spawn_t     e;
        int         act;
        prev_spawn = 4'b0000;
        forever begin
            @(negedge clk);
            if (spawn != 4'b0000) begin
                checks++;
                if (!$onehot(spawn)) begin
                    errors++;
                    $display("FAIL onehot cycle %0d spawn=%b required one-hot", cyc, spawn);
                end
                checks++;
                if ((spawn & prev_spawn) != 4'b0000) begin
                    errors++;
                    $display("FAIL back_to_back cycle %0d spawn=%b prev=%b", cyc, spawn, prev_spawn);
                end
                if (spawn_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_spawn cycle %0d spawn=%b required 0000", cyc, spawn);
                end else begin
                    e = spawn_q.pop_front();
                    checks++;
                    if (e.cyc != cyc) begin
                        errors++;
                        $display("FAIL spawn_cycle actual %0d required %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (spawn != 4'(1 << e.lane)) begin
                        errors++;
                        $display("FAIL spawn_lane cycle %0d spawn=%b required lane %0d", cyc, spawn, e.lane);
                    end
                    checks++;
                    if (int'(spawn_count) != e.count) begin
                        errors++;
                        $display("FAIL spawn_count_at_pulse cycle %0d actual %0d required %0d", cyc, spawn_count, e.count);
                    end
                    checks++;
                    if (int'(cur_interval) != e.interval) begin
                        errors++;
                        $display("FAIL interval_at_pulse cycle %0d actual %0d required %0d", cyc, cur_interval, e.interval);
                    end
                end
            end
            while (spawn_q.size() > 0 && spawn_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missing_spawn cycle %0d required lane %0d at cycle %0d", cyc, spawn_q[0].lane, spawn_q[0].cyc);
                void'(spawn_q.pop_front());
            end
            for (int i = chk_q.size() - 1; i >= 0; i--) begin
                if (chk_q[i].cyc <= cyc) begin
                    case (chk_q[i].kind)
                        K_STATE:    act = int'({q_Idle, q_Run, q_Spawn, q_Halt});
                        K_COUNT:    act = int'(spawn_count);
                        K_INTERVAL: act = int'(cur_interval);
                        default:    act = int'(spawn);
                    endcase
                    checks++;
                    if (chk_q[i].cyc < cyc || act != chk_q[i].value) begin
                        errors++;
                        $display("FAIL %s cycle %0d actual %0d required %0d", kind_name(chk_q[i].kind), chk_q[i].cyc, act, chk_q[i].value);
                    end
                    chk_q.delete(i);
                end
            end
            prev_spawn = spawn;
        end
    end

    initial begin
        rst_n = 1'b0;
        timer_tick = 1'b0;
        play_flag = 1'b1;
        gameover_ctrl = 1'b0;
        lane_empty = 4'hF;
        m_lfsr = SEED;
        @(posedge clk);
        #1;
        assert_reset();
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Random lane occupancy through the whole ramp
        for (int i = 0; i < 150; i++) tick_once(4'($urandom_range(0, 15)), 1'b1);

        // All lanes free until well past counter saturation
        for (int i = 0; i < 3000 && m_spawns < 300; i++) tick_once(4'hF, 1'b1);

        // Game over in the cycle a free lane is found
        run_to_expiry(4'hF);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // New game, then reset while the pulse is out
        run_to_expiry(4'hF);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        assert_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Lanes after reseed follow the seed sequence again
        for (int i = 0; i < 30; i++) tick_once(4'($urandom_range(0, 15)), 1'b1);
        repeat (20) cycle(1'b0, 1'b1, 1'b0);

        checks++;
        if (spawn_q.size() != 0 || chk_q.size() != 0) begin
            errors++;
            $display("FAIL drained actual %0d/%0d pending required 0/0", spawn_q.size(), chk_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
